instr_encoder_loader: RTL and testbench

//  Field-to-machine-word encoder: the write side of the instruction decoder's op/funct/rd scheme.

---
 rtl/instr_encoder_loader_if.sv | 30 +++
 rtl/instr_encoder_loader.sv | 77 +++++++
 tb/tb_instr_encoder_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: record input and memory write port of the instruction loader.
// The master drives records and mem_ready; the slave is the loader itself.
interface instr_encoder_loader_if #(parameter int AW = 32);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_kind;
    logic [3:0]    in_cond;
    logic [3:0]    in_cmd;
    logic          in_s;
    logic          in_imm;
    logic          in_l;
    logic [3:0]    in_rn;
    logic [3:0]    in_rd;
    logic [11:0]   in_src2;
    logic [23:0]   in_imm24;
    logic          mem_we;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    modport master (
        output in_valid, in_kind, in_cond, in_cmd, in_s, in_imm, in_l,
               in_rn, in_rd, in_src2, in_imm24, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  in_valid, in_kind, in_cond, in_cmd, in_s, in_imm, in_l,
               in_rn, in_rd, in_src2, in_imm24, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded instruction records into ARM words and streams them
// into instruction memory through a registered write port, one session of up to DEPTH words.
module instr_encoder_loader #(
    parameter int            DEPTH = 64,
    parameter int            AW    = 32,
    parameter logic [AW-1:0] BASE  = '0,
    localparam int           CW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    start,
    instr_encoder_loader_if.slave   bus,
    output logic [CW-1:0]           count,
    output logic                    busy,
    output logic                    full,
    output logic                    err
);
    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
    state_t      state, state_nx;
    logic        commit, accept, legal;
    logic [CW:0] issued;
    logic [31:0] word;

    assign commit = bus.mem_we & bus.mem_ready;
    assign accept = bus.in_valid & bus.in_ready & ~start;
    assign legal  = bus.in_kind != 2'b11;
    // issued counts the word still waiting in the write register, so acceptance never overshoots DEPTH
    assign issued = {1'b0, count} + (CW+1)'(bus.mem_we);

    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = state;
        if (start) state_nx = LOAD;
        else if (state == LOAD && commit && count == CW'(DEPTH - 1)) state_nx = FULL;
    end

    always_comb begin
        busy         = state == LOAD;
        full         = state == FULL;
        bus.in_ready = busy & (~bus.mem_we | bus.mem_ready) & (issued < (CW+1)'(DEPTH));
    end

    // memory form is always pre-indexed, up, word, no writeback
    always_comb
        word = bus.in_kind == 2'b00 ? {bus.in_cond, 2'b00, bus.in_imm, bus.in_cmd, bus.in_s,
                                       bus.in_rn, bus.in_rd, bus.in_src2}
             : bus.in_kind == 2'b01 ? {bus.in_cond, 2'b01, ~bus.in_imm, 4'b1100, bus.in_l,
                                       bus.in_rn, bus.in_rd, bus.in_src2}
             :                        {bus.in_cond, 4'b1010, bus.in_imm24};

    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE;
            bus.mem_wdata <= '0;
            count         <= '0;
            err           <= 1'b0;
        end else if (start) begin
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= BASE;
            count        <= '0;
            err          <= 1'b0;
        end else if (busy) begin
            if (commit) begin
                count        <= count + CW'(1);
                bus.mem_addr <= bus.mem_addr + AW'(4);
            end
            if (accept && legal) begin
                bus.mem_we    <= 1'b1;
                bus.mem_wdata <= word;
            end else if (commit) bus.mem_we <= 1'b0;
            if (accept && !legal) err <= 1'b1;
        end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: scoreboard bench; accepted records push expected (addr, word)
// pairs from a field-level reference model, a negedge monitor pops them on every commit.
module tb_instr_encoder_loader;
    localparam int          DEPTH = 4;
    localparam int          AW    = 32;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        s;
        logic        imm;
        logic        l;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
    } rec_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic          clk = 0, n_reset = 0, start = 0;
    logic [CW-1:0] count;
    logic          busy, full, err;
    exp_t          q[$];
    int            checks = 0, errors = 0, issued = 0, commits = 0;
    bit            merr = 0, rnd_ready = 0;

    instr_encoder_loader_if #(.AW(AW)) bus();

    instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW), .BASE(BASE)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .bus(bus.slave),
        .count(count), .busy(busy), .full(full), .err(err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ARM field placement: cond, class, then class-specific fields
    function automatic logic [31:0] model_word(input rec_t r);
        longint w;
        w = (longint'(r.cond) << 28) | (longint'(r.kind) << 26);
        case (r.kind)
            2'd0: w |= (longint'(r.imm) << 25) | (longint'(r.cmd) << 21) | (longint'(r.s) << 20)
                     | (longint'(r.rn) << 16) | (longint'(r.rd) << 12) | longint'(r.src2);
            2'd1: w |= (longint'(!r.imm) << 25) | (64'd1 << 24) | (64'd1 << 23)
                     | (longint'(r.l) << 20) | (longint'(r.rn) << 16) | (longint'(r.rd) << 12)
                     | longint'(r.src2);
            default: w |= (64'd1 << 25) | longint'(r.imm24);
        endcase
        return w[31:0];
    endfunction

    function automatic rec_t rnd_rec(input bit allow_illegal);
        rec_t r;
        r = rec_t'({$urandom, $urandom});
        r.kind = (allow_illegal && $urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        return r;
    endfunction

    function automatic rec_t mk(input logic [1:0] kind, input logic [3:0] cmd, input logic imm,
                                input logic l, input logic [3:0] rn, input logic [3:0] rd,
                                input logic [11:0] src2, input logic [23:0] imm24);
        return '{kind: kind, cond: 4'hE, cmd: cmd, s: 1'b0, imm: imm, l: l,
                 rn: rn, rd: rd, src2: src2, imm24: imm24};
    endfunction

    task automatic send(input rec_t r);
        bit acc = 0;
        bus.in_kind = r.kind;  bus.in_cond = r.cond;  bus.in_cmd = r.cmd;
        bus.in_s = r.s;        bus.in_imm = r.imm;    bus.in_l = r.l;
        bus.in_rn = r.rn;      bus.in_rd = r.rd;      bus.in_src2 = r.src2;
        bus.in_imm24 = r.imm24;
        bus.in_valid = 1;
        if (issued == DEPTH)
            repeat (5) begin
                @(negedge clk);
                chk("ready_when_full", bus.in_ready, 0);
            end
        else begin
            for (int i = 0; i < 200 && !acc; i++) begin
                @(negedge clk);
                acc = bus.in_ready;
            end
            chk("accept_timeout", acc, 1);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            if (r.kind == 2'b11) merr = 1;
            else begin
                q.push_back('{addr: BASE + 32'(4 * issued), data: model_word(r)});
                issued++;
            end
        end
        bus.in_valid = 0;
    endtask

    task automatic do_start();
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        q.delete();
        issued = 0;
        commits = 0;
        merr = 0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (q.size() == 0) && !bus.mem_we;
        end
        chk("drain", done, 1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (n_reset) begin
            exp_t e;
            chk("count", count, commits);
            chk("full", full, commits == DEPTH);
            chk("err", err, merr);
            if (bus.mem_we && !bus.mem_ready) chk("ready_during_stall", bus.in_ready, 0);
            if (bus.mem_we && bus.mem_ready) begin
                chk("write_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("mem_addr", bus.mem_addr, e.addr);
                    chk("mem_wdata", bus.mem_wdata, e.data);
                    commits++;
                end
            end
        end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) bus.mem_ready = $urandom_range(0, 3) != 0;
    end

    initial begin
        rec_t r;
        bus.in_valid = 0; bus.in_kind = 0; bus.in_cond = 0; bus.in_cmd = 0; bus.in_s = 0;
        bus.in_imm = 0; bus.in_l = 0; bus.in_rn = 0; bus.in_rd = 0; bus.in_src2 = 0;
        bus.in_imm24 = 0; bus.mem_ready = 1;
        #7;
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, BASE);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        n_reset = 1;
        // data-processing word with one-cycle latency
        do_start();
        chk("t1_busy", busy, 1);
        send(mk(2'd0, 4'd4, 1'b1, 1'b0, 4'd1, 4'd2, 12'h005, 24'h0));
        chk("t1_we", bus.mem_we, 1);
        chk("t1_addr", bus.mem_addr, 32'h0);
        chk("t1_wdata", bus.mem_wdata, 32'hE2812005);
        wait_drain();
        // load then store, back to back
        do_start();
        send(mk(2'd1, 4'd0, 1'b1, 1'b1, 4'd0, 4'd3, 12'h010, 24'h0));
        chk("t2_ldr_addr", bus.mem_addr, 32'h0);
        chk("t2_ldr_wdata", bus.mem_wdata, 32'hE5903010);
        send(mk(2'd1, 4'd0, 1'b1, 1'b0, 4'd0, 4'd3, 12'h010, 24'h0));
        chk("t2_str_addr", bus.mem_addr, 32'h4);
        chk("t2_str_wdata", bus.mem_wdata, 32'hE5803010);
        wait_drain();
        chk("t2_count", count, 2);
        // branch, then a three-cycle memory stall with a record waiting
        do_start();
        send(mk(2'd2, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 12'h0, 24'hFFFFFE));
        chk("t3_wdata", bus.mem_wdata, 32'hEAFFFFFE);
        r = rnd_rec(0);
        fork
            send(r);
            begin
                bus.mem_ready = 0;
                repeat (3) begin
                    @(negedge clk);
                    chk("t4_hold_we", bus.mem_we, 1);
                    chk("t4_hold_addr", bus.mem_addr, 32'h0);
                    chk("t4_hold_wdata", bus.mem_wdata, 32'hEAFFFFFE);
                    chk("t4_hold_ready", bus.in_ready, 0);
                end
                @(posedge clk);
                #1;
                bus.mem_ready = 1;
            end
        join
        chk("t4_nobubble_we", bus.mem_we, 1);
        chk("t4_nobubble_addr", bus.mem_addr, 32'h4);
        chk("t4_nobubble_wdata", bus.mem_wdata, model_word(r));
        wait_drain();
        // fill the session past DEPTH
        do_start();
        repeat (6) send(rnd_rec(0));
        wait_drain();
        chk("t5_full", full, 1);
        chk("t5_count", count, DEPTH);
        chk("t5_in_ready", bus.in_ready, 0);
        do_start();
        chk("t5_restart_busy", busy, 1);
        chk("t5_restart_count", count, 0);
        // illegal kind between legal records, then async reset with a held write
        send(mk(2'd0, 4'd2, 1'b0, 1'b0, 4'd5, 4'd6, 12'h123, 24'h0));
        send(mk(2'd3, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 12'h0, 24'h0));
        send(mk(2'd0, 4'd3, 1'b1, 1'b0, 4'd7, 4'd8, 12'h0FF, 24'h0));
        wait_drain();
        chk("t6_err", err, 1);
        chk("t6_count", count, 2);
        bus.mem_ready = 0;
        send(rnd_rec(0));
        #2;
        n_reset = 0;
        #1;
        chk("t6_rst_we", bus.mem_we, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_addr", bus.mem_addr, BASE);
        chk("t6_rst_ready", bus.in_ready, 0);
        q.delete();
        issued = 0;
        commits = 0;
        merr = 0;
        @(posedge clk);
        #1;
        n_reset = 1;
        bus.mem_ready = 1;
        // random sessions with random memory backpressure
        rnd_ready = 1;
        repeat (12) begin
            do_start();
            repeat ($urandom_range(1, 7)) send(rnd_rec(1));
            wait_drain();
        end
        rnd_ready = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
